// File: rtl/aes_ecb_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module : aes_ecb_job_sequencer
// Brief  : Drives an AES-ECB core through a multi-block job (key load, N
//          blocks in, N ciphertexts out, sticky irq / timeout error).
// Rev    : 1.0
// ============================================================================
module aes_ecb_job_sequencer #(
  parameter int DATA_W      = 128,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [CNT_W-1:0]  cfg_num_blocks,
  input  logic [DATA_W-1:0] cfg_key,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] core_key,
  output logic              core_key_load,
  output logic [DATA_W-1:0] core_din,
  output logic              core_start,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_dout,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  blocks_done,
  output logic              irq,
  input  logic              irq_clear,
  output logic              err_timeout
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_KEY_LOAD  = 3'd1,
    S_WAIT_IN   = 3'd2,
    S_START     = 3'd3,
    S_WAIT_CORE = 3'd4,
    S_OUTPUT    = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  blocks_q, blocks_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              irq_q, irq_d;
  logic              err_q, err_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      din_q    <= '0;
      dout_q   <= '0;
      num_q    <= '0;
      blocks_q <= '0;
      tcnt_q   <= '0;
      irq_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      din_q    <= din_d;
      dout_q   <= dout_d;
      num_q    <= num_d;
      blocks_q <= blocks_d;
      tcnt_q   <= tcnt_d;
      irq_q    <= irq_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    din_d    = din_q;
    dout_d   = dout_q;
    num_d    = num_q;
    blocks_d = blocks_q;
    tcnt_d   = tcnt_q;
    irq_d    = irq_q;
    err_d    = err_q;

    // Clear first so a set later in the same cycle takes priority.
    if (irq_clear) begin
      irq_d = 1'b0;
      err_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          blocks_d = '0;
          if (cfg_num_blocks != '0) begin
            key_d   = cfg_key;
            num_d   = cfg_num_blocks;
            state_d = S_KEY_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_KEY_LOAD: state_d = S_WAIT_IN;
      S_WAIT_IN: begin
        if (in_valid) begin
          din_d   = in_data;
          state_d = S_START;
        end
      end
      S_START: begin
        tcnt_d  = '0;
        state_d = S_WAIT_CORE;
      end
      S_WAIT_CORE: begin
        tcnt_d = tcnt_q + 1'b1;
        if (core_done) begin
          dout_d  = core_dout;
          state_d = S_OUTPUT;
        end else if (tcnt_q == TCNT_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          blocks_d = blocks_q + 1'b1;
          state_d  = (blocks_d == num_q) ? S_DONE : S_WAIT_IN;
        end
      end
      S_DONE: begin
        irq_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready      = (state_q == S_WAIT_IN);
  assign core_key_load = (state_q == S_KEY_LOAD);
  assign core_start    = (state_q == S_START);
  assign out_valid     = (state_q == S_OUTPUT);
  assign busy          = (state_q != S_IDLE);
  assign core_key      = key_q;
  assign core_din      = din_q;
  assign out_data      = dout_q;
  assign blocks_done   = blocks_q;
  assign irq           = irq_q;
  assign err_timeout   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_ecb_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_aes_ecb_job_sequencer
// Brief  : Randomized self-checking bench with a behavioural core and a
//          job-level scoreboard for aes_ecb_job_sequencer.
// Rev    : 1.0
// ============================================================================
module tb_aes_ecb_job_sequencer;

  localparam int DATA_W      = 128;
  localparam int CNT_W       = 8;
  localparam int TIMEOUT_CYC = 64;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic              clock = 1'b0;
  logic              reset;
  logic              cfg_start;
  logic [CNT_W-1:0]  cfg_num_blocks;
  logic [DATA_W-1:0] cfg_key;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] core_key;
  logic              core_key_load;
  logic [DATA_W-1:0] core_din;
  logic              core_start;
  logic              core_done;
  logic [DATA_W-1:0] core_dout;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
  logic [CNT_W-1:0]  blocks_done;
  logic              irq;
  logic              irq_clear;
  logic              err_timeout;

  aes_ecb_job_sequencer #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clock(clock), .reset(reset),
    .cfg_start(cfg_start), .cfg_num_blocks(cfg_num_blocks), .cfg_key(cfg_key),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .core_key(core_key), .core_key_load(core_key_load),
    .core_din(core_din), .core_start(core_start),
    .core_done(core_done), .core_dout(core_dout),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .blocks_done(blocks_done),
    .irq(irq), .irq_clear(irq_clear), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] job_key;
  int           core_lat;
  int           bp_cycles;
  bit           rand_bp;
  int           gap_pct;
  logic [127:0] in_q[$];
  logic [127:0] exp_q[$];
  logic [127:0] last_out;
  int n_out, n_kl, n_cs, cyc;
  int last_hs_cyc, irq_rise_cyc, err_rise_cyc, start_cyc;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Stand-in core: any deterministic non-identity mapping, plus the FIPS-197 vector.
  function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] d);
    if (k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
    return {d[94:0], d[127:95]} ^ k ^ 128'h5a5a_3c3c_0f0f_9696_a5a5_c3c3_f0f0_6969;
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Behavioural core with latency core_lat.
  initial begin
    int cnt;
    logic [127:0] cap_k, cap_d;
    cnt = 0; cap_k = '0; cap_d = '0;
    core_done = 1'b0; core_dout = '0;
    forever begin
      @(posedge clock); #1;
      core_done = 1'b0;
      if (reset) cnt = 0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_done = 1'b1;
          core_dout = core_f(cap_k, cap_d);
        end
      end
      @(negedge clock);
      if (!reset && core_done) check("din_held", core_din, cap_d);
      if (!reset && core_start) begin
        cnt = core_lat; cap_k = core_key; cap_d = core_din;
      end
    end
  end

  // Plaintext source with random gaps.
  initial begin
    in_valid = 1'b0; in_data = '0;
    forever begin
      @(posedge clock); #1;
      if (!reset && in_q.size() > 0 && $urandom_range(0, 99) >= 32'(gap_pct)) begin
        in_valid = 1'b1; in_data = in_q[0];
      end else in_valid = 1'b0;
      @(negedge clock);
      if (!reset && in_valid && in_ready) begin
        void'(in_q.pop_front());
        exp_q.push_back(core_f(job_key, in_data));
      end
    end
  end

  // Ciphertext sink with backpressure and stability checks.
  initial begin
    int stall;
    logic held_v;
    logic [127:0] held;
    stall = 0; held_v = 1'b0; held = '0; out_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      out_ready = (stall >= bp_cycles);
      @(negedge clock);
      if (reset) begin
        stall = 0; held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("ov_held", 128'(out_valid), 128'd1);
          check("od_held", out_data, held);
        end
        held_v = 1'b0;
        if (out_valid && !out_ready) begin
          stall++; held_v = 1'b1; held = out_data;
        end else if (out_valid && out_ready) begin
          n_out++; last_hs_cyc = cyc; stall = 0; last_out = out_data;
          if (exp_q.size() == 0) check("unexpected_out", 128'd1, 128'd0);
          else check("out_data", out_data, exp_q.pop_front());
          if (rand_bp) bp_cycles = $urandom_range(0, 3);
        end
      end
    end
  end

  // Event monitor.
  initial begin
    logic prev_done, prev_irq, prev_err;
    prev_done = 1'b0; prev_irq = 1'b0; prev_err = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (core_key_load) n_kl++;
        if (core_start) begin n_cs++; start_cyc = cyc; end
        if (prev_done && core_lat <= TIMEOUT_CYC) check("done_to_ov", 128'(out_valid), 128'd1);
        if (irq && !prev_irq) irq_rise_cyc = cyc;
        if (err_timeout && !prev_err) err_rise_cyc = cyc;
      end
      prev_done = core_done && !reset;
      prev_irq  = irq;
      prev_err  = err_timeout;
    end
  end

  task automatic push_pts(input int n);
    for (int i = 0; i < n; i++) in_q.push_back({$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic clear_irq();
    @(posedge clock); #1 irq_clear = 1'b1;
    @(posedge clock); #1 irq_clear = 1'b0;
    @(negedge clock);
    check("irq_cleared", 128'(irq), 128'd0);
    check("err_cleared", 128'(err_timeout), 128'd0);
  endtask

  task automatic run_job(input logic [127:0] key, input int num, input int lat, input int bp,
                         input int gap, input bit rnd, input bit clr_on_done, input bit exp_to);
    int kl0, cs0, bound, waited, exp_blk;
    bit irq0;
    @(posedge clock); #1;
    job_key = key; core_lat = lat; bp_cycles = bp; rand_bp = rnd; gap_pct = gap; n_out = 0;
    kl0 = n_kl; cs0 = n_cs; irq0 = irq;
    cfg_key = key; cfg_num_blocks = CNT_W'(num); cfg_start = 1'b1;
    @(posedge clock); #1 cfg_start = 1'b0;
    @(negedge clock);
    check("busy_after_start", 128'(busy), 128'd1);
    check("key_load_latency", 128'(core_key_load), 128'(num != 0));
    bound = 300 + num * (lat + bp + 40);
    waited = 0;
    if (clr_on_done) begin
      while (!(out_valid && out_ready && blocks_done == CNT_W'(num - 1)) && waited < bound) begin
        @(negedge clock); waited++;
      end
      @(posedge clock); #1 irq_clear = 1'b1;
      @(posedge clock); #1 irq_clear = 1'b0;
      @(negedge clock);
      check("irq_set_wins", 128'(irq), 128'd1);
    end
    while (busy && waited < bound) begin
      @(negedge clock); waited++;
    end
    exp_blk = exp_to ? 0 : num;
    check("job_finished", 128'(busy), 128'd0);
    check("irq_at_end", 128'(irq), 128'd1);
    check("err_timeout", 128'(err_timeout), 128'(exp_to));
    check("blocks_done", 128'(blocks_done), 128'(exp_blk));
    check("outputs", 128'(n_out), 128'(exp_blk));
    check("key_loads", 128'(n_kl - kl0), 128'(num != 0));
    check("core_starts", 128'(n_cs - cs0), 128'(exp_to ? 1 : num));
    if (exp_to) begin
      exp_q.delete();
      check("err_latency", 128'(err_rise_cyc - start_cyc), 128'(TIMEOUT_CYC + 1));
      if (!irq0) check("irq_latency_to", 128'(irq_rise_cyc - start_cyc), 128'(TIMEOUT_CYC + 2));
    end else begin
      check("exp_drained", 128'(exp_q.size()), 128'd0);
      if (num != 0 && !irq0 && !clr_on_done)
        check("irq_latency", 128'(irq_rise_cyc - last_hs_cyc), 128'd2);
    end
    if (num == 0) check("num0_busy_cycles", 128'(waited), 128'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k1, k2;
    int waited;
    reset = 1'b1; cfg_start = 1'b0; cfg_num_blocks = '0; cfg_key = '0; irq_clear = 1'b0;
    job_key = '0; core_lat = 10; bp_cycles = 0; rand_bp = 1'b0; gap_pct = 0;
    n_out = 0; n_kl = 0; n_cs = 0; cyc = 0; last_out = '0;
    last_hs_cyc = 0; irq_rise_cyc = 0; err_rise_cyc = 0; start_cyc = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_irq", 128'(irq), 128'd0);
    check("rst_err", 128'(err_timeout), 128'd0);
    check("rst_outs", 128'({in_ready, out_valid, core_key_load, core_start}), 128'd0);
    check("rst_key", core_key, 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_blocks", 128'(blocks_done), 128'd0);
    #2 reset = 1'b0;

    in_q.push_back(FIPS_PT);
    run_job(FIPS_KEY, 1, 10, 0, 0, 1'b0, 1'b0, 1'b0);
    check("fips_ct", last_out, FIPS_CT);
    clear_irq();

    push_pts(4);
    run_job({$urandom, $urandom, $urandom, $urandom}, 4, 12, 3, 50, 1'b0, 1'b0, 1'b0);
    check("blocks_held_idle", 128'(blocks_done), 128'd4);
    clear_irq();

    run_job({$urandom, $urandom, $urandom, $urandom}, 0, 10, 0, 0, 1'b0, 1'b0, 1'b0);
    clear_irq();

    push_pts(1);
    run_job({$urandom, $urandom, $urandom, $urandom}, 1, TIMEOUT_CYC, 0, 0, 1'b0, 1'b0, 1'b0);
    clear_irq();

    push_pts(1);
    run_job({$urandom, $urandom, $urandom, $urandom}, 1, 100, 0, 0, 1'b0, 1'b0, 1'b1);
    clear_irq();
    repeat (50) @(negedge clock);

    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = ~k1;
    push_pts(3);
    fork
      run_job(k1, 3, 8, 1, 0, 1'b0, 1'b1, 1'b0);
      begin
        repeat (15) @(posedge clock);
        #1 cfg_key = k2; cfg_num_blocks = 8'd5; cfg_start = 1'b1;
        @(posedge clock); #1 cfg_start = 1'b0;
        @(negedge clock);
        check("key_not_relatched", core_key, k1);
      end
    join

    job_key = {$urandom, $urandom, $urandom, $urandom};
    core_lat = 20; bp_cycles = 0; rand_bp = 1'b0; gap_pct = 0; n_out = 0;
    push_pts(3);
    @(posedge clock); #1;
    cfg_key = job_key; cfg_num_blocks = 8'd3; cfg_start = 1'b1;
    @(posedge clock); #1 cfg_start = 1'b0;
    @(negedge clock);
    check("irq_sticky_new_job", 128'(irq), 128'd1);
    waited = 0;
    while (!core_start && waited < 100) begin @(negedge clock); waited++; end
    check("saw_core_start", 128'(core_start), 128'd1);
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_flags", 128'({irq, err_timeout, in_ready, out_valid, core_start, core_key_load}), 128'd0);
    check("midrst_key", core_key, 128'd0);
    check("midrst_din", core_din, 128'd0);
    check("midrst_out", out_data, 128'd0);
    check("midrst_blocks", 128'(blocks_done), 128'd0);
    in_q.delete(); exp_q.delete(); n_out = 0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    push_pts(3);
    run_job({$urandom, $urandom, $urandom, $urandom}, 3, 15, 1, 20, 1'b0, 1'b0, 1'b0);
    clear_irq();

    for (int j = 0; j < 8; j++) begin
      int n;
      n = $urandom_range(1, 6);
      push_pts(n);
      run_job({$urandom, $urandom, $urandom, $urandom}, n, $urandom_range(1, TIMEOUT_CYC),
              $urandom_range(0, 3), $urandom_range(0, 60), 1'b1, 1'b0, 1'b0);
      clear_irq();
    end

    push_pts(255);
    run_job({$urandom, $urandom, $urandom, $urandom}, 255, 1, 0, 0, 1'b0, 1'b0, 1'b0);
    clear_irq();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
